// File: rtl/lfsr_stream.sv
// lfsr_stream: parametrised LFSR test-pattern generator with a valid/ready
// output stream. Each accepted advance applies the single-step LFSR function
// STEP times in one cycle (Fibonacci or Galois form). An all-zero result, or
// an all-zero load value, is replaced by SEED and flagged on `lockup`. The
// generator remembers its start state and reports on `wrap` when the sequence
// returns to it, publishing the number of advances of the full cycle on
// `period`.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   enable      in   permits advancing
//   load        in   one-cycle strobe: restart from load_value
//   load_value  in   [WIDTH]  new start state (zero is replaced by SEED)
//   out_data    out  [WIDTH]  current state, registered
//   out_valid   out  out_data holds an unconsumed word
//   out_ready   in   consumer accepts the word
//   lockup      out  one-cycle pulse: an all-zero state was replaced by SEED
//   wrap        out  one-cycle pulse: advanced state equals the start state
//   period      out  [CNT_W]  advances per full cycle, from the last wrap
module lfsr_stream #(
  parameter int               WIDTH = 28,
  parameter logic [WIDTH-1:0] TAPS  = 28'h9000000,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               MODE  = 0,
  parameter int               STEP  = 1,
  parameter int               CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lockup,
  output logic             wrap,
  output logic [CNT_W-1:0] period
);

  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] step_once(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    if (MODE == 0) r = {s[WIDTH-2:0], ^(s & TAPS)};
    else           r = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] t;
    t = s;
    for (int i = 0; i < STEP; i++) t = step_once(t);
    return t;
  endfunction

  // The advance counter sticks at all-ones rather than rolling over.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  logic [WIDTH-1:0] state_p1, start_p1;
  logic             vld_p1, lockup_p1, wrap_p1;
  logic [CNT_W-1:0] cnt_p1, period_p1;

  logic [WIDTH-1:0] raw_p0, nxt_p0, ld_eff_p0;
  logic             zero_adv_p0, zero_ld_p0, fire_p0, wrap_hit_p0;
  logic [CNT_W-1:0] cnt_inc_p0;

  // Stage p0: combinational multi-step advance, load substitution, handshake
  always_comb begin
    raw_p0      = advance(state_p1);
    zero_adv_p0 = (raw_p0 == ZERO);
    nxt_p0      = zero_adv_p0 ? SEED : raw_p0;
    zero_ld_p0  = (load_value == ZERO);
    ld_eff_p0   = zero_ld_p0 ? SEED : load_value;
    // A pending word under backpressure blocks firing, which freezes the state.
    fire_p0     = enable & (~vld_p1 | out_ready) & ~load;
    wrap_hit_p0 = (nxt_p0 == start_p1);
    cnt_inc_p0  = sat_inc(cnt_p1);
  end

  // Stage p1: registered state, stream flags and cycle statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p1  <= SEED;
      start_p1  <= SEED;
      vld_p1    <= 1'b0;
      lockup_p1 <= 1'b0;
      wrap_p1   <= 1'b0;
      cnt_p1    <= '0;
      period_p1 <= '0;
    end else begin
      lockup_p1 <= 1'b0;
      wrap_p1   <= 1'b0;
      if (load) begin
        state_p1  <= ld_eff_p0;
        start_p1  <= ld_eff_p0;
        vld_p1    <= 1'b0;
        cnt_p1    <= '0;
        lockup_p1 <= zero_ld_p0;
      end else if (fire_p0) begin
        state_p1  <= nxt_p0;
        vld_p1    <= 1'b1;
        lockup_p1 <= zero_adv_p0;
        if (wrap_hit_p0) begin
          wrap_p1   <= 1'b1;
          period_p1 <= cnt_inc_p0;
          cnt_p1    <= '0;
        end else begin
          cnt_p1    <= cnt_inc_p0;
        end
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_data  = state_p1;
  assign out_valid = vld_p1;
  assign lockup    = lockup_p1;
  assign wrap      = wrap_p1;
  assign period    = period_p1;

endmodule
